// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC unit: next-PC selection with one delay slot, hazard stall,
// illegal-target trap with sticky fault, and a taken-redirect debug counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter int          AW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch,
  input  logic          zero,
  input  logic          jump,
  input  logic          jr,
  input  logic [31:0]   pc4_id,
  input  logic [15:0]   imm16,
  input  logic [25:0]   instr_index,
  input  logic [31:0]   rs_data,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [AW-1:0] im_addr,
  output logic          fault,
  output logic [31:0]   fault_pc,
  output logic [31:0]   redirect_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  // Upper bound is held in 33 bits so a memory ending at 2^32 cannot wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  logic [31:0] btarget;
  logic [31:0] jtarget;
  logic [31:0] candidate;
  logic        is_redirect;
  logic        illegal;
  logic [31:0] pc_offset;

  assign btarget = pc4_id + {{14{imm16[15]}}, imm16, 2'b00};
  assign jtarget = {pc4_id[31:28], instr_index, 2'b00};

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    candidate   = pc_q + 32'd4;
    is_redirect = 1'b0;
    if (jr) begin
      candidate   = rs_data;
      is_redirect = 1'b1;
    end else if (jump) begin
      candidate   = jtarget;
      is_redirect = 1'b1;
    end else if (branch && zero) begin
      candidate   = btarget;
      is_redirect = 1'b1;
    end
  end

  assign illegal = (candidate[1:0] != 2'b00)
                || (candidate < RESET_PC)
                || ({1'b0, candidate} >= PC_LIMIT);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    fault_pc_d     = fault_pc_q;
    redirect_cnt_d = redirect_cnt_q;
    if (state_q == ST_RUN && !stall) begin
      if (illegal) begin
        state_d    = ST_FAULT;
        fault_pc_d = candidate;
      end else begin
        pc_d = candidate;
        if (is_redirect) redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      fault_pc_q     <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fault_pc_q     <= fault_pc_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign pc_offset    = pc_q - RESET_PC;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign im_addr      = pc_offset[AW+1:2];
  assign fault        = (state_q == ST_FAULT);
  assign fault_pc     = fault_pc_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: each task drives one scenario and checks
// hand-computed PC, address, fault and counter values at the falling edge.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        jr;
  logic [31:0] pc4_id;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [11:0] im_addr;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] redirect_cnt;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .jr           (jr),
    .pc4_id       (pc4_id),
    .imm16        (imm16),
    .instr_index  (instr_index),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .im_addr      (im_addr),
    .fault        (fault),
    .fault_pc     (fault_pc),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    stall = 0; branch = 0; zero = 0; jump = 0; jr = 0;
    pc4_id = 32'd0; imm16 = 16'd0; instr_index = 26'd0; rs_data = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    do_reset();
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    total++; if (pc_plus4 !== 32'h3004) begin bad++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'h3004); end
    total++; if (fault !== 1'b0 || fault_pc !== 32'd0) begin bad++; $display("FAIL reset_fault got=%b/%h exp=0/0", fault, fault_pc); end
    total++; if (redirect_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", redirect_cnt); end
    for (int i = 0; i <= 3; i++) begin
      exp_pc = 32'h3000 + 32'(4 * i);
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc); end
      total++; if (im_addr !== 12'(i)) begin bad++; $display("FAIL seq_im_addr[%0d] got=%0d exp=%0d", i, im_addr, i); end
      total++; if (redirect_cnt !== 32'd0) begin bad++; $display("FAIL seq_cnt[%0d] got=%h exp=0", i, redirect_cnt); end
      step();
    end
  endtask

  task automatic test_branch();
    do_reset();
    branch = 1; zero = 1; pc4_id = 32'h3010; imm16 = 16'hFFFC;
    step();
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL beq_taken_pc got=%h exp=%h", pc, 32'h3000); end
    total++; if (redirect_cnt !== 32'd1) begin bad++; $display("FAIL beq_taken_cnt got=%h exp=1", redirect_cnt); end
    zero = 0;
    step();
    total++; if (pc !== 32'h3004) begin bad++; $display("FAIL beq_not_taken_pc got=%h exp=%h", pc, 32'h3004); end
    total++; if (redirect_cnt !== 32'd1) begin bad++; $display("FAIL beq_not_taken_cnt got=%h exp=1", redirect_cnt); end
    branch = 1; zero = 1; pc4_id = 32'h3008; imm16 = 16'h0010;
    step();
    total++; if (pc !== 32'h3048) begin bad++; $display("FAIL beq_fwd_pc got=%h exp=%h", pc, 32'h3048); end
    total++; if (redirect_cnt !== 32'd2) begin bad++; $display("FAIL beq_fwd_cnt got=%h exp=2", redirect_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1; jump = 1; instr_index = 26'hC10; pc4_id = 32'h3010;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (pc !== 32'h3000) begin bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, pc, 32'h3000); end
      total++; if (redirect_cnt !== 32'd0) begin bad++; $display("FAIL stall_cnt[%0d] got=%h exp=0", i, redirect_cnt); end
    end
    stall = 0;
    step();
    total++; if (pc !== 32'h3040) begin bad++; $display("FAIL stall_release_pc got=%h exp=%h", pc, 32'h3040); end
    total++; if (redirect_cnt !== 32'd1) begin bad++; $display("FAIL stall_release_cnt got=%h exp=1", redirect_cnt); end
    jump = 0;
    step();
    total++; if (pc !== 32'h3044 || redirect_cnt !== 32'd1) begin bad++; $display("FAIL after_jump got=%h/%h exp=3044/1", pc, redirect_cnt); end
  endtask

  task automatic test_illegal();
    do_reset();
    jr = 1; rs_data = 32'h3002;
    step();
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL misalign_pc got=%h exp=%h", pc, 32'h3000); end
    total++; if (fault !== 1'b1 || fault_pc !== 32'h3002) begin bad++; $display("FAIL misalign_fault got=%b/%h exp=1/3002", fault, fault_pc); end
    total++; if (redirect_cnt !== 32'd0) begin bad++; $display("FAIL misalign_cnt got=%h exp=0", redirect_cnt); end
    rs_data = 32'h3100; jump = 1; instr_index = 26'hC10;
    step();
    jr = 0; jump = 0;
    step();
    total++; if (pc !== 32'h3000 || fault !== 1'b1 || fault_pc !== 32'h3002) begin bad++; $display("FAIL sticky got=%h/%b/%h exp=3000/1/3002", pc, fault, fault_pc); end
    do_reset();
    total++; if (pc !== 32'h3000 || fault !== 1'b0 || fault_pc !== 32'd0) begin bad++; $display("FAIL fault_reset got=%h/%b/%h exp=3000/0/0", pc, fault, fault_pc); end

    jr = 1; rs_data = 32'h7000;
    step();
    total++; if (fault !== 1'b1 || fault_pc !== 32'h7000 || pc !== 32'h3000) begin bad++; $display("FAIL jr_high got=%b/%h/%h exp=1/7000/3000", fault, fault_pc, pc); end

    do_reset();
    jr = 1; rs_data = 32'h2FFC;
    step();
    total++; if (fault !== 1'b1 || fault_pc !== 32'h2FFC) begin bad++; $display("FAIL jr_low got=%b/%h exp=1/2ffc", fault, fault_pc); end

    do_reset();
    jr = 1; rs_data = 32'h6FFC;
    step();
    total++; if (pc !== 32'h6FFC || fault !== 1'b0 || redirect_cnt !== 32'd1) begin bad++; $display("FAIL jr_last_word got=%h/%b/%h exp=6ffc/0/1", pc, fault, redirect_cnt); end
    jr = 0;
    step();
    total++; if (pc !== 32'h6FFC || fault !== 1'b1 || fault_pc !== 32'h7000) begin bad++; $display("FAIL seq_runoff got=%h/%b/%h exp=6ffc/1/7000", pc, fault, fault_pc); end
    total++; if (redirect_cnt !== 32'd1) begin bad++; $display("FAIL seq_runoff_cnt got=%h exp=1", redirect_cnt); end
  endtask

  task automatic test_priority();
    do_reset();
    jr = 1; jump = 1; branch = 1; zero = 1;
    rs_data = 32'h3100; instr_index = 26'hC10; pc4_id = 32'h3010; imm16 = 16'hFFFC;
    step();
    total++; if (pc !== 32'h3100 || redirect_cnt !== 32'd1) begin bad++; $display("FAIL prio_jr got=%h/%h exp=3100/1", pc, redirect_cnt); end
    jr = 0;
    step();
    total++; if (pc !== 32'h3040 || redirect_cnt !== 32'd2) begin bad++; $display("FAIL prio_jump got=%h/%h exp=3040/2", pc, redirect_cnt); end
    jump = 0;
    step();
    total++; if (pc !== 32'h3000 || redirect_cnt !== 32'd3) begin bad++; $display("FAIL prio_branch got=%h/%h exp=3000/3", pc, redirect_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    step();
    stall = 1; jump = 1; instr_index = 26'hC10;
    step();
    total++; if (pc !== 32'h3004) begin bad++; $display("FAIL mid_stall_hold got=%h exp=%h", pc, 32'h3004); end
    reset = 1;
    step();
    reset = 0; stall = 0; jump = 0;
    total++; if (pc !== 32'h3000 || redirect_cnt !== 32'd0 || fault !== 1'b0) begin bad++; $display("FAIL mid_stall_reset got=%h/%h/%b exp=3000/0/0", pc, redirect_cnt, fault); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.redirect_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.redirect_cnt_q;
    total++; if (redirect_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", redirect_cnt); end
    branch = 1; zero = 1; pc4_id = 32'h3010; imm16 = 16'hFFFC;
    step();
    total++; if (redirect_cnt !== 32'd0 || pc !== 32'h3000) begin bad++; $display("FAIL wrap got=%h/%h exp=0/3000", redirect_cnt, pc); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_branch();
    test_stall();
    test_illegal();
    test_priority();
    test_reset_mid_stall();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-stage program-counter unit of the 5-stage pipelined CPU.
- Consumes the ID-stage compare result `zero` and the decoded branch, jump and jr controls.
- Holds the PC register, selects next-PC (sequential, branch, j/jal, jr) with one delay slot, honours hazard stalls, and drives the instruction-memory word address.
- Traps illegal fetch targets with a sticky fault, and counts taken redirects for debug.

Parameters:
RESET_PC  32'h0000_3000  PC value after reset; base of instruction memory
IM_WORDS  4096  instruction-memory depth in words; must be a power of two
AW  12  instruction-memory word-address width, equal to log2(IM_WORDS)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit freeze of the IF stage; PC holds
branch  input  1  ID instruction is beq
zero  input  1  ID-stage compare result; 1 means the operands are equal
jump  input  1  ID instruction is j or jal
jr  input  1  ID instruction is jr
pc4_id  input  32  PC+4 of the instruction currently in ID
imm16  input  16  ID branch offset in words
instr_index  input  26  ID jump target field
rs_data  input  32  forwarded rs value for jr
pc  output  32  current fetch PC
pc_plus4  output  32  pc + 4, registered into IF/ID downstream
im_addr  output  AW  (pc - RESET_PC) >> 2, truncated to AW bits
fault  output  1  sticky illegal-fetch-target flag
fault_pc  output  32  offending target that raised fault
redirect_cnt  output  32  number of accepted taken redirects

Behaviour:
- Reset: clk rising edge with reset=1 sets pc=RESET_PC, fault=0, fault_pc=0, redirect_cnt=0. Reset overrides every other input, including a set fault.
- pc_plus4 and im_addr are combinational from pc. Fetch latency is 0: im_addr is valid in the same cycle as pc.
- Target arithmetic is 32-bit, with wrap-around ignored:
  - btarget = pc4_id + (sign_ext(imm16) << 2)
  - jtarget = {pc4_id[31:28], instr_index, 2'b00}
  - jrtarget = rs_data
- Next-PC priority, highest first, evaluated each edge when reset=0:
  1. fault=1: pc holds.
  2. stall=1: pc holds. All redirects are ignored this cycle; the stalled ID instruction presents them again when the stall releases.
  3. jr=1: candidate is jrtarget.
  4. jump=1: candidate is jtarget.
  5. branch=1 and zero=1: candidate is btarget.
  6. Otherwise: candidate is pc+4. branch=1 with zero=0 also falls through here.
- Multiple redirect controls asserted together is a decoder error. The priority above resolves it deterministically.
- Delay slot: targets are relative to pc4_id, so the slot instruction at pc4_id is already fetched and always executes. The unit never flushes.
- Legality check on the candidate, applied to every source including pc+4:
  - The candidate is illegal if candidate[1:0]≠0, or candidate<RESET_PC, or candidate≥RESET_PC+4*IM_WORDS.
  - On an illegal candidate: pc holds, fault←1, fault_pc←candidate, redirect_cnt is unchanged.
  - fault is sticky until reset.
- Counter: redirect_cnt increments by 1 on each edge where a legal candidate from source 3, 4 or 5 is loaded. It wraps from 0xFFFF_FFFF to 0.
- States: RUN while fault=0, FAULT while fault=1.
  - RUN→FAULT on an illegal candidate.
  - FAULT→RUN only via reset.
  - Reset asserted mid-stall or mid-redirect returns the unit to RUN with pc=RESET_PC on that edge.

Test Plan:
- Reset then 3 free-running cycles: pc = 0x3000, then 0x3004, 0x3008, 0x300C; im_addr = 0, 1, 2, 3; redirect_cnt = 0.
- Taken beq: branch=1, zero=1, pc4_id=0x3010, imm16=0xFFFC → next pc=0x3000, redirect_cnt=1. Same inputs with zero=0 → pc advances by 4, redirect_cnt unchanged.
- Stall interplay: stall=1 with jump=1, instr_index=0xC10 → pc holds for 2 cycles. On stall release → pc=0x3040, redirect_cnt increments exactly once.
- Illegal targets:
  - jr=1, rs_data=0x3002 → pc holds, fault=1, fault_pc=0x3002. Later inputs are ignored until reset; reset restores pc=0x3000, fault=0.
  - jr=1, rs_data=0x7000 → fault, fault_pc=0x7000.
  - Sequential fetch running off 0x6FFC → fault_pc=0x7000.
- Priority: jr=1, jump=1, branch=1, zero=1 asserted together, rs_data=0x3100 → pc=0x3100.
- Counter wrap: bench forces redirect_cnt=0xFFFF_FFFF, then one taken beq → redirect_cnt=0.
